// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and key event record
// for the PS/2 key event controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    localparam int unsigned EVENT_W = 8 + 1 + 1 + 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } key_event_t;

    // Letters take shift XOR caps; every other printable key takes shift alone.
    function automatic logic is_letter(input logic [7:0] code);
        return code inside {8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Key event stream: FIFO head payload with valid/ready handshake.
interface ps2_key_event_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] ev_ascii;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                    input  ev_ready);
    modport slave  (input  ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                    output ev_ready);
endinterface

// File: rtl/ps2_ascii_lut.sv
// Scan set 2 to ASCII table: letters, digits with shifted symbols,
// space, enter and backspace. Unknown codes map to 0x00.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii_c
);

    always_comb begin
        ascii_c = 8'h00;
        case (code)
            8'h1C: ascii_c = 8'h61;  8'h32: ascii_c = 8'h62;  8'h21: ascii_c = 8'h63;
            8'h23: ascii_c = 8'h64;  8'h24: ascii_c = 8'h65;  8'h2B: ascii_c = 8'h66;
            8'h34: ascii_c = 8'h67;  8'h33: ascii_c = 8'h68;  8'h43: ascii_c = 8'h69;
            8'h3B: ascii_c = 8'h6A;  8'h42: ascii_c = 8'h6B;  8'h4B: ascii_c = 8'h6C;
            8'h3A: ascii_c = 8'h6D;  8'h31: ascii_c = 8'h6E;  8'h44: ascii_c = 8'h6F;
            8'h4D: ascii_c = 8'h70;  8'h15: ascii_c = 8'h71;  8'h2D: ascii_c = 8'h72;
            8'h1B: ascii_c = 8'h73;  8'h2C: ascii_c = 8'h74;  8'h3C: ascii_c = 8'h75;
            8'h2A: ascii_c = 8'h76;  8'h1D: ascii_c = 8'h77;  8'h22: ascii_c = 8'h78;
            8'h35: ascii_c = 8'h79;  8'h1A: ascii_c = 8'h7A;
            8'h16: ascii_c = upper ? 8'h21 : 8'h31;
            8'h1E: ascii_c = upper ? 8'h40 : 8'h32;
            8'h26: ascii_c = upper ? 8'h23 : 8'h33;
            8'h25: ascii_c = upper ? 8'h24 : 8'h34;
            8'h2E: ascii_c = upper ? 8'h25 : 8'h35;
            8'h36: ascii_c = upper ? 8'h5E : 8'h36;
            8'h3D: ascii_c = upper ? 8'h26 : 8'h37;
            8'h3E: ascii_c = upper ? 8'h2A : 8'h38;
            8'h46: ascii_c = upper ? 8'h28 : 8'h39;
            8'h45: ascii_c = upper ? 8'h29 : 8'h30;
            8'h29: ascii_c = 8'h20;
            8'h5A: ascii_c = 8'h0D;
            8'h66: ascii_c = 8'h08;
            default: ascii_c = 8'h00;
        endcase
        if (upper && is_letter(code)) ascii_c = ascii_c - 8'h20;
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan byte sequencer: decodes make/break/extended events, tracks
// shift/caps, suppresses typematic repeat and queues events in a FIFO.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    ps2_key_event_ctrl_if.master          ev_if,
    output logic                          shift,
    output logic                          caps,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    dec_state_e        state_q, state_d;
    logic [8:0]        held_q, held_d;
    logic              held_vld_q, held_vld_d;
    logic              lshift_q, lshift_d, rshift_q, rshift_d;
    logic              shift_q, shift_d, caps_q, caps_d;
    logic              pend_vld_q, pend_vld_d;
    key_event_t        pend_q, pend_d;
    key_event_t        head_q, head_d;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [EVENT_W-1:0] mem [FIFO_DEPTH];

    logic       emit_c, emit_ext_c, emit_brk_c, held_hit_c, accept_c, upper_c;
    logic       pop_c, push_c, full_c;
    logic [7:0] lut_ascii_c;

    // Shift/caps state before this byte's own modifier update
    assign upper_c = is_letter(byte_data) ? ((lshift_q | rshift_q) ^ caps_q)
                                          : (lshift_q | rshift_q);

    ps2_ascii_lut u_lut (
        .code    (byte_data),
        .upper   (upper_c),
        .ascii_c (lut_ascii_c)
    );

    // Prefix decoder plus repeat filter and modifier tracking
    always_comb begin
        state_d    = state_q;
        emit_c     = 1'b0;
        emit_ext_c = 1'b0;
        emit_brk_c = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == SC_EXT)      state_d = ST_EXT;
                    else if (byte_data == SC_BRK) state_d = ST_BRK;
                    else if (!(byte_data inside {SC_PAUSE, SC_BAT, SC_ACK, SC_ECHO}))
                        emit_c = 1'b1;
                end
                ST_EXT: begin
                    if (byte_data == SC_BRK) state_d = ST_EXTBRK;
                    else if (byte_data != SC_EXT) begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit_c     = 1'b1;
                    emit_brk_c = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    emit_c     = 1'b1;
                    emit_ext_c = 1'b1;
                    emit_brk_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            endcase
        end

        held_hit_c = SUPPRESS_REPEAT && held_vld_q && (held_q == {emit_ext_c, byte_data});
        accept_c   = emit_c && !(held_hit_c && !emit_brk_c);

        held_d     = held_q;
        held_vld_d = held_vld_q;
        if (emit_c && emit_brk_c && held_hit_c) held_vld_d = 1'b0;
        if (accept_c && !emit_brk_c) begin
            held_d     = {emit_ext_c, byte_data};
            held_vld_d = 1'b1;
        end

        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        if (accept_c && !emit_ext_c) begin
            if (byte_data == SC_LSHIFT) lshift_d = !emit_brk_c;
            if (byte_data == SC_RSHIFT) rshift_d = !emit_brk_c;
            if (byte_data == SC_CAPS && !emit_brk_c) caps_d = !caps_q;
        end
        shift_d = lshift_d | rshift_d;

        pend_vld_d   = accept_c;
        pend_d       = pend_q;
        if (accept_c) begin
            pend_d.code  = byte_data;
            pend_d.ext   = emit_ext_c;
            pend_d.brk   = emit_brk_c;
            pend_d.ascii = (emit_brk_c || emit_ext_c) ? 8'h00 : lut_ascii_c;
        end
    end

    // Event FIFO; the head is held in a register so it persists when empty
    always_comb begin
        pop_c    = valid_q & ev_if.ev_ready;
        full_c   = (count_q == CNT_W'(FIFO_DEPTH));
        push_c   = pend_vld_q & (!full_c | pop_c);
        ovf_d    = ovf_q | (pend_vld_q & full_c & !pop_c);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        valid_d  = (count_d != '0);
        head_d   = head_q;
        if (pop_c) begin
            if (count_q > CNT_W'(1)) head_d = key_event_t'(mem[rd_ptr_q + PTR_W'(1)]);
            else if (push_c)         head_d = pend_q;
        end else if (count_q == '0 && push_c) begin
            head_d = pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            shift_q    <= 1'b0;
            caps_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            shift_q    <= shift_d;
            caps_q     <= caps_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign ev_if.ev_valid = valid_q;
    assign ev_if.ev_code  = head_q.code;
    assign ev_if.ev_ext   = head_q.ext;
    assign ev_if.ev_break = head_q.brk;
    assign ev_if.ev_ascii = head_q.ascii;
    assign shift          = shift_q;
    assign caps           = caps_q;
    assign overflow       = ovf_q;
    assign ev_count       = count_q;

endmodule
